ic_hd_coefficient_reconstruction: RTL and testbench

Decoder-side inverse of the Huffman coding preparation stage. Consumes decoded symbols as (amplitude bits, RSL word) pairs, expands zero runs, sign-restores amplitudes, and emits exactly 64 signed 13-bit coefficients per block in zig-zag order, with ready/valid on both sides. It sits between the Huffman symbol decoder and the de-zigzag/dequantisation stage.

---
 rtl/ic_hd_coefficient_reconstruction.sv | 166 ++++++++++++++++
 tb/tb_ic_hd_coefficient_reconstruction.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ic_hd_coefficient_reconstruction.sv
// Rebuilds 64 zig-zag coefficients per block from (amplitude, RSL) symbols: run expansion, sign restore, EOB fill.
// One-entry output register, symbol-to-coefficient latency 1 cycle; both sides stall while the slot is occupied.
module ic_hd_coefficient_reconstruction #(
  parameter int BLOCK_LEN = 64,
  parameter int MAX_SIZE  = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [12:0] sym_value,
  input  logic [12:0] sym_rsl,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic [12:0] coef_data,
  output logic [5:0]  coef_index,
  output logic        coef_last,
  output logic        err_run_overflow,
  output logic        err_proto
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);
  localparam logic [3:0] SIZE_CAP = 4'(MAX_SIZE);

  typedef enum logic [1:0] {S_ACCEPT, S_RUN, S_FILL} state_t;

  state_t      state, state_n;
  logic [5:0]  idx, idx_n;
  logic [6:0]  run_cnt, run_cnt_n;
  logic [12:0] held_val, held_n;
  logic        blk_full, blk_full_n;
  logic        ovf_n, proto_n;
  logic        load;
  logic [12:0] load_val;

  logic        free, accept, at_last, is_eob, is_dc, size_bad;
  logic [3:0]  size_eff;
  logic [12:0] amp_mask, amp_raw, amp;
  logic [6:0]  total_run;

  assign free      = !coef_valid || coef_ready;
  assign sym_ready = reset_n && (state == S_ACCEPT) && free;
  assign accept    = sym_valid && sym_ready;
  assign at_last   = (idx == LAST_IDX);
  assign is_eob    = sym_rsl[12];
  assign is_dc     = (idx == 6'd0) || blk_full;
  assign total_run = {1'b0, sym_rsl[11:10], 4'd0} + {1'b0, sym_rsl[9:4]};

  // Negative amplitudes are coded with a clear MSB: value = amp - (2^size - 1).
  always_comb begin
    size_bad = (sym_rsl[3:0] > SIZE_CAP);
    size_eff = size_bad ? SIZE_CAP : sym_rsl[3:0];
    amp_mask = (13'd1 << size_eff) - 13'd1;
    amp_raw  = sym_value & amp_mask;
    if (|(amp_raw & (amp_mask ^ (amp_mask >> 1))))
      amp = amp_raw;
    else
      amp = amp_raw - amp_mask;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    run_cnt_n  = run_cnt;
    held_n     = held_val;
    blk_full_n = blk_full;
    ovf_n      = err_run_overflow;
    proto_n    = err_proto;
    load       = 1'b0;
    load_val   = '0;
    unique case (state)
      S_ACCEPT: begin
        if (accept) begin
          if (is_eob) begin
            if (blk_full)
              blk_full_n = 1'b0;
            else if (idx == 6'd0)
              proto_n = 1'b1;
            else
              state_n = S_FILL;
          end else begin
            if (size_bad)
              proto_n = 1'b1;
            if (blk_full) begin
              proto_n    = 1'b1;
              blk_full_n = 1'b0;
            end
            load = 1'b1;
            if (is_dc || total_run == 7'd0) begin
              load_val = amp;
              if (at_last && !is_dc)
                blk_full_n = 1'b1;
            end else if (at_last) begin
              ovf_n = 1'b1;
            end else begin
              run_cnt_n = total_run - 7'd1;
              held_n    = amp;
              state_n   = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        if (free) begin
          load = 1'b1;
          if (run_cnt != 7'd0) begin
            run_cnt_n = run_cnt - 7'd1;
            // Zero landed on the last slot with run still pending: truncate the block.
            if (at_last) begin
              ovf_n   = 1'b1;
              state_n = S_ACCEPT;
            end
          end else begin
            load_val = held_val;
            if (at_last)
              blk_full_n = 1'b1;
            state_n = S_ACCEPT;
          end
        end
      end
      S_FILL: begin
        if (free) begin
          load = 1'b1;
          if (at_last)
            state_n = S_ACCEPT;
        end
      end
      default: state_n = S_ACCEPT;
    endcase
    if (load)
      idx_n = at_last ? 6'd0 : idx + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_ACCEPT;
      idx              <= '0;
      run_cnt          <= '0;
      held_val         <= '0;
      blk_full         <= 1'b0;
      err_run_overflow <= 1'b0;
      err_proto        <= 1'b0;
      coef_valid       <= 1'b0;
      coef_data        <= '0;
      coef_index       <= '0;
      coef_last        <= 1'b0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      run_cnt          <= run_cnt_n;
      held_val         <= held_n;
      blk_full         <= blk_full_n;
      err_run_overflow <= ovf_n;
      err_proto        <= proto_n;
      if (load) begin
        coef_valid <= 1'b1;
        coef_data  <= load_val;
        coef_index <= idx;
        coef_last  <= at_last;
      end else if (coef_ready) begin
        coef_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ic_hd_coefficient_reconstruction.sv
// Directed bench: symbol streams with hand-built expected coefficient lists, backpressure and error cases.
module tb_ic_hd_coefficient_reconstruction;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sym_valid, sym_ready;
  logic [12:0] sym_value, sym_rsl;
  logic        coef_valid, coef_ready;
  logic [12:0] coef_data;
  logic [5:0]  coef_index;
  logic        coef_last;
  logic        err_run_overflow, err_proto;
  logic [19:0] cur;

  int checks = 0;
  int failures = 0;

  logic [12:0] sv_q[$];
  logic [12:0] sr_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];

  always #5 clk = ~clk;
  assign cur = {coef_last, coef_index, coef_data};

  ic_hd_coefficient_reconstruction dut (
    .clk(clk), .reset_n(reset_n),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_value(sym_value), .sym_rsl(sym_rsl),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_index(coef_index), .coef_last(coef_last),
    .err_run_overflow(err_run_overflow), .err_proto(err_proto)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_sym(input logic [12:0] v, input logic eob, input logic [1:0] m16,
                         input logic [5:0] run, input logic [3:0] size);
    sv_q.push_back(v);
    sr_q.push_back({eob, m16, run, size});
  endtask

  task automatic exp_val(input int idx, input int val);
    logic [5:0]  i6;
    logic [12:0] v13;
    i6  = idx[5:0];
    v13 = val[12:0];
    exp_q.push_back({(idx == 63), i6, v13});
  endtask

  task automatic exp_zeros(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_val(i, 0);
  endtask

  task automatic present();
    if (sv_q.size() > 0) begin
      sym_valid = 1'b1;
      sym_value = sv_q[0];
      sym_rsl   = sr_q[0];
    end else begin
      sym_valid = 1'b0;
      sym_value = '0;
      sym_rsl   = '0;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    sym_valid  = 1'b0;
    sym_value  = '0;
    sym_rsl    = '0;
    coef_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives the queued symbols, collects accepted coefficients and compares against exp_q.
  task automatic run_scn(input string tag, input bit bp, input bit chk_lat);
    int cyc, idle, t_acc, t_val, n;
    logic sacc, cacc, held, busy;
    logic [19:0] held_v;
    got_q.delete();
    cyc = 0; idle = 0; t_acc = -1; t_val = -1;
    held = 1'b0; busy = 1'b0; held_v = '0;
    @(posedge clk);
    #1;
    present();
    coef_ready = !bp;
    while (cyc < 2000 && idle < 4) begin
      @(negedge clk);
      if (held) check_eq({tag, "_hold"}, {11'd0, coef_valid, cur}, {11'd0, 1'b1, held_v});
      if (busy) check_eq({tag, "_busy"}, {31'd0, sym_ready}, 32'd0);
      cacc   = coef_valid && coef_ready;
      sacc   = sym_valid && sym_ready;
      held   = coef_valid && !coef_ready;
      held_v = cur;
      busy   = bp && sacc && (sym_rsl[12] || sym_rsl[9:4] != 6'd0);
      if (cacc) got_q.push_back(cur);
      if (sacc && t_acc < 0) t_acc = cyc;
      if (coef_valid && t_val < 0) t_val = cyc;
      if (sv_q.size() == 0 && !coef_valid) idle++;
      else idle = 0;
      @(posedge clk);
      #1;
      if (sacc) begin
        void'(sv_q.pop_front());
        void'(sr_q.pop_front());
        present();
      end
      if (bp) coef_ready = !coef_ready;
      cyc++;
    end
    check_eq({tag, "_done"}, {31'd0, idle >= 4}, 32'd1);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_c%0d", tag, i), {12'd0, got_q[i]}, {12'd0, exp_q[i]});
    if (chk_lat) check_eq({tag, "_lat"}, t_val - t_acc, 32'd1);
    exp_q.delete();
    sv_q.delete();
    sr_q.delete();
    sym_valid  = 1'b0;
    coef_ready = 1'b1;
  endtask

  task automatic check_flags(input string tag, input logic ovf, input logic proto);
    check_eq({tag, "_ovf"}, {31'd0, err_run_overflow}, {31'd0, ovf});
    check_eq({tag, "_proto"}, {31'd0, err_proto}, {31'd0, proto});
  endtask

  initial begin
    reset_n = 1'b0; sym_valid = 1'b0; sym_value = '0; sym_rsl = '0; coef_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_sym_ready_low", {31'd0, sym_ready}, 32'd0);
    do_reset();
    @(negedge clk);
    check_eq("rst_valid", {31'd0, coef_valid}, 32'd0);
    check_eq("rst_out", {12'd0, cur}, 32'd0);
    check_eq("rst_sym_ready", {31'd0, sym_ready}, 32'd1);
    check_flags("rst", 1'b0, 1'b0);

    // DC +5, AC -1, EOB fill
    add_sym(13'd5, 0, 0, 0, 3); add_sym(13'd0, 0, 0, 0, 1); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, 5); exp_val(1, -1); exp_zeros(2, 63);
    run_scn("t1", 0, 1);

    // DC size 0, AC total run 35 with -2
    add_sym(13'd7, 0, 0, 0, 0); add_sym(13'd1, 0, 2'd2, 6'd3, 2); add_sym(13'd0, 1, 0, 0, 0);
    exp_zeros(0, 35); exp_val(36, -2); exp_zeros(37, 63);
    run_scn("t2", 0, 1);

    // backpressure through a run of 10; upper value bits ignored
    add_sym(13'd0, 0, 0, 0, 12); add_sym(13'h1FFA, 0, 0, 6'd10, 3); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, -4095); exp_zeros(1, 10); exp_val(11, -5); exp_zeros(12, 63);
    run_scn("t3", 1, 1);
    check_flags("t3", 1'b0, 1'b0);

    // full block, trailing EOB swallowed, next block starts at index 0
    for (int i = 0; i < 64; i++) begin add_sym(13'd1, 0, 0, 0, 1); exp_val(i, 1); end
    add_sym(13'd0, 1, 0, 0, 0);
    add_sym(13'd5, 0, 0, 0, 3); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, 5); exp_zeros(1, 63);
    run_scn("t4", 0, 0);
    check_flags("t4", 1'b0, 1'b0);

    // full block followed by a non-EOB symbol
    for (int i = 0; i < 64; i++) begin add_sym(13'd1, 0, 0, 0, 1); exp_val(i, 1); end
    add_sym(13'd3, 0, 0, 0, 2); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, 3); exp_zeros(1, 63);
    run_scn("t5", 0, 0);
    check_flags("t5", 1'b0, 1'b1);
    do_reset();

    // run overflow from index 61
    for (int i = 0; i <= 60; i++) begin add_sym(13'd1, 0, 0, 0, 1); exp_val(i, 1); end
    add_sym(13'd9, 0, 0, 6'd5, 4);
    exp_zeros(61, 63);
    run_scn("t6", 0, 0);
    check_flags("t6", 1'b1, 1'b0);
    add_sym(13'd5, 0, 0, 0, 3); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, 5); exp_zeros(1, 63);
    run_scn("t6b", 0, 1);
    check_flags("t6b", 1'b1, 1'b0);
    do_reset();

    // EOB as the first symbol
    add_sym(13'd0, 1, 0, 0, 0);
    run_scn("t7", 0, 0);
    check_flags("t7", 1'b0, 1'b1);
    do_reset();

    // oversize field clamps to 12
    add_sym(13'd0, 0, 0, 0, 4'd15); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, -4095); exp_zeros(1, 63);
    run_scn("t8", 0, 0);
    check_flags("t8", 1'b0, 1'b1);
    do_reset();

    // reset in the middle of an EOB fill
    sym_valid = 1'b1; sym_value = '0; sym_rsl = 13'h1000;
    @(posedge clk); #1;
    sym_value = 13'd1; sym_rsl = 13'h0001;
    @(posedge clk); #1;
    sym_value = 13'd0; sym_rsl = 13'h1000;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("t9_fill_valid", {31'd0, coef_valid}, 32'd1);
    check_eq("t9_pre_proto", {31'd0, err_proto}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t9_rst_valid", {31'd0, coef_valid}, 32'd0);
    check_eq("t9_rst_index", {26'd0, coef_index}, 32'd0);
    check_eq("t9_rst_last", {31'd0, coef_last}, 32'd0);
    check_flags("t9_rst", 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t9_sym_ready", {31'd0, sym_ready}, 32'd1);
    add_sym(13'd5, 0, 0, 0, 3); add_sym(13'd0, 1, 0, 0, 0);
    exp_val(0, 5); exp_zeros(1, 63);
    run_scn("t9", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
